// File: rtl/ex_issue_ctrl.sv
// Execute-stage issue controller: latches ALU operands/op from a decoded request,
// captures the combinational ALU result and holds it for a valid/ready consumer.
module ex_issue_ctrl #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       aluop,
    input  logic [10:0]      opcode,
    input  logic [WIDTH-1:0] rd_a,
    input  logic [WIDTH-1:0] rd_b,
    input  logic [WIDTH-1:0] imm,
    input  logic             alusrc,
    output logic [WIDTH-1:0] alu_num1,
    output logic [WIDTH-1:0] alu_num2,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_z,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_z,
    output logic             res_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_HOLD = 2'b10
    } state_e;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_ORR  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] num1_q, num1_d;
    logic [WIDTH-1:0] num2_q, num2_d;
    logic [3:0]       op_q, op_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_z_q, res_z_d;
    logic             res_err_q, res_err_d;
    logic             res_valid_q, res_valid_d;
    logic [3:0]       dec_op;
    logic             dec_err;

    // ALU control decode; unsupported R/I encodings fall back to ADD and flag an error
    always_comb begin
        dec_op  = OP_ADD;
        dec_err = 1'b0;
        case (aluop)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_PASS;
            2'b10: begin
                case (opcode)
                    11'b10001011000: dec_op = OP_ADD;
                    11'b11001011000: dec_op = OP_SUB;
                    11'b10001010000: dec_op = OP_AND;
                    11'b10101010000: dec_op = OP_ORR;
                    default:         dec_err = 1'b1;
                endcase
            end
            default: begin
                case (opcode[10:1])
                    10'b1001000100: dec_op = OP_ADD;
                    10'b1101000100: dec_op = OP_SUB;
                    10'b1001001000: dec_op = OP_AND;
                    10'b1011001000: dec_op = OP_ORR;
                    default:        dec_err = 1'b1;
                endcase
            end
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        num1_d      = num1_q;
        num2_d      = num2_q;
        op_d        = op_q;
        err_d       = err_q;
        res_data_d  = res_data_q;
        res_z_d     = res_z_q;
        res_err_d   = res_err_q;
        res_valid_d = res_valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    num1_d  = rd_a;
                    num2_d  = alusrc ? imm : rd_b;
                    op_d    = dec_op;
                    err_d   = dec_err;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                res_data_d  = alu_out;
                res_z_d     = alu_z;
                res_err_d   = err_q;
                res_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            num1_q      <= '0;
            num2_q      <= '0;
            op_q        <= OP_AND;
            err_q       <= 1'b0;
            res_data_q  <= '0;
            res_z_q     <= 1'b0;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            num1_q      <= num1_d;
            num2_q      <= num2_d;
            op_q        <= op_d;
            err_q       <= err_d;
            res_data_q  <= res_data_d;
            res_z_q     <= res_z_d;
            res_err_q   <= res_err_d;
            res_valid_q <= res_valid_d;
        end
    end

    // Acceptance decodes straight from the state register; reset forces it low
    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign alu_num1  = num1_q;
    assign alu_num2  = num2_q;
    assign alu_op    = op_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_z     = res_z_q;
    assign res_err   = res_err_q;

endmodule
